// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris game core: move kinds, the
// move-validator state encoding and signed board-coordinate sizing.
package tetris_pkg;

    typedef enum logic [1:0] {
        KIND_AT    = 2'd0,
        KIND_DOWN  = 2'd1,
        KIND_LEFT  = 2'd2,
        KIND_RIGHT = 2'd3
    } check_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH  = 10;
    localparam int DEFAULT_HEIGHT = 20;
    localparam int DEFAULT_GRID   = 4;

    // Signed width able to hold a board extent plus a full grid margin on either side.
    function automatic int coord_width(input int extent, input int grid);
        return $clog2(extent + 2 * grid) + 1;
    endfunction

endpackage

// File: rtl/piece_row_collision.sv
// Combinational check of one piece-grid row against board walls, floor and
// the fixed-state screen.
module piece_row_collision
    import tetris_pkg::*;
#(
    parameter int FIXED_STATE_WIDTH  = DEFAULT_WIDTH,
    parameter int FIXED_STATE_HEIGHT = DEFAULT_HEIGHT,
    parameter int GRID               = DEFAULT_GRID,
    parameter int AXW                = 7,
    parameter int AYW                = 7,
    parameter int RW                 = 2
) (
    input  logic [GRID-1:0]                                  row_cells,
    input  logic signed [AXW-1:0]                            anchor_x,
    input  logic signed [AYW-1:0]                            anchor_y,
    input  logic [RW-1:0]                                    row_idx,
    input  logic [FIXED_STATE_WIDTH-1:0][FIXED_STATE_HEIGHT-1:0] fixed_screen,
    output logic                                             row_oob,
    output logic                                             row_overlap
);

    localparam int CIW = (FIXED_STATE_WIDTH  > 1) ? $clog2(FIXED_STATE_WIDTH)  : 1;
    localparam int RIW = (FIXED_STATE_HEIGHT > 1) ? $clog2(FIXED_STATE_HEIGHT) : 1;

    // Screen lookup only happens once the cell is known to be on the board.
    always_comb begin
        int col_i;
        int row_i;
        row_oob     = 1'b0;
        row_overlap = 1'b0;
        col_i       = 0;
        row_i       = int'(anchor_y) + int'(row_idx);
        for (int c = 0; c < GRID; c++) begin
            col_i = int'(anchor_x) + c;
            if (row_cells[c]) begin
                if (col_i < 0 || col_i >= FIXED_STATE_WIDTH || row_i >= FIXED_STATE_HEIGHT) begin
                    row_oob = 1'b1;
                end else if (row_i >= 0 && fixed_screen[col_i[CIW-1:0]][row_i[RIW-1:0]]) begin
                    row_overlap = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/piece_move_validator.sv
// Sequential cell-exact move check: latches a move request, scans the piece
// one grid row per cycle and returns collision flags through valid/ready.
module piece_move_validator
    import tetris_pkg::*;
#(
    parameter  int FIXED_STATE_WIDTH  = DEFAULT_WIDTH,
    parameter  int FIXED_STATE_HEIGHT = DEFAULT_HEIGHT,
    parameter  int GRID               = DEFAULT_GRID,
    localparam int XW = coord_width(FIXED_STATE_WIDTH, GRID),
    localparam int YW = coord_width(FIXED_STATE_HEIGHT, GRID)
) (
    input  logic                                             clk,
    input  logic                                             reset_n,
    input  logic                                             req_valid,
    output logic                                             req_ready,
    input  check_kind_t                                      req_kind,
    input  logic [GRID-1:0][GRID-1:0]                        req_grid,
    input  logic signed [XW-1:0]                             req_x,
    input  logic signed [YW-1:0]                             req_y,
    input  logic [FIXED_STATE_WIDTH-1:0][FIXED_STATE_HEIGHT-1:0] fixed_screen,
    output logic                                             resp_valid,
    input  logic                                             resp_ready,
    output logic                                             resp_collision,
    output logic                                             resp_out_of_bounds,
    output logic                                             resp_overlap,
    output logic                                             resp_landed
);

    localparam int RW = (GRID > 1) ? $clog2(GRID) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(GRID - 1);
    localparam logic signed [XW:0] X_ONE = (XW + 1)'(1);
    localparam logic signed [YW:0] Y_ONE = (YW + 1)'(1);

    state_t                    state, state_nx;
    check_kind_t               kind_q;
    logic [GRID-1:0][GRID-1:0] grid_q;
    logic signed [XW:0]        ex_q, ex_next;
    logic signed [YW:0]        ey_q, ey_next;
    logic [RW-1:0]             row_q;
    logic                      oob_q, ovl_q;
    logic [GRID-1:0]           row_cells;
    logic                      row_oob, row_overlap;

    // One extra bit on the anchor keeps the +/-1 move offset from wrapping.
    always_comb begin
        ex_next = {req_x[XW-1], req_x};
        ey_next = {req_y[YW-1], req_y};
        unique case (req_kind)
            KIND_DOWN:  ey_next = ey_next + Y_ONE;
            KIND_LEFT:  ex_next = ex_next - X_ONE;
            KIND_RIGHT: ex_next = ex_next + X_ONE;
            default:    ;
        endcase
    end

    always_comb begin
        row_cells = '0;
        for (int c = 0; c < GRID; c++) begin
            row_cells[c] = grid_q[c][row_q];
        end
    end

    piece_row_collision #(
        .FIXED_STATE_WIDTH  (FIXED_STATE_WIDTH),
        .FIXED_STATE_HEIGHT (FIXED_STATE_HEIGHT),
        .GRID               (GRID),
        .AXW                (XW + 1),
        .AYW                (YW + 1),
        .RW                 (RW)
    ) u_row_check (
        .row_cells    (row_cells),
        .anchor_x     (ex_q),
        .anchor_y     (ey_q),
        .row_idx      (row_q),
        .fixed_screen (fixed_screen),
        .row_oob      (row_oob),
        .row_overlap  (row_overlap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latch, row counter and sticky hit accumulation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kind_q <= KIND_AT;
            grid_q <= '0;
            ex_q   <= '0;
            ey_q   <= '0;
            row_q  <= '0;
            oob_q  <= 1'b0;
            ovl_q  <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            kind_q <= req_kind;
            grid_q <= req_grid;
            ex_q   <= ex_next;
            ey_q   <= ey_next;
            row_q  <= '0;
            oob_q  <= 1'b0;
            ovl_q  <= 1'b0;
        end else if (state == SCAN) begin
            oob_q  <= oob_q | row_oob;
            ovl_q  <= ovl_q | row_overlap;
            row_q  <= row_q + RW'(1);
        end
    end

    always_comb begin
        state_nx           = state;
        req_ready          = 1'b0;
        resp_valid         = 1'b0;
        resp_out_of_bounds = 1'b0;
        resp_overlap       = 1'b0;
        resp_collision     = 1'b0;
        resp_landed        = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = SCAN;
            end
            SCAN: begin
                if (row_q == LAST_ROW) state_nx = DONE;
            end
            DONE: begin
                resp_valid         = 1'b1;
                resp_out_of_bounds = oob_q;
                resp_overlap       = ovl_q;
                resp_collision     = oob_q | ovl_q;
                resp_landed        = (oob_q | ovl_q) && (kind_q == KIND_DOWN);
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
